// File: rtl/letc_core_mem_arbiter_if.sv
// Bundled request/response signals between the core requesters (IF, LS) and
// the shared memory port. The arbiter takes the slave view; the surrounding logic takes the master view.
interface letc_core_mem_arbiter_if;
    logic        i_if_req_valid;
    logic        o_if_req_ready;
    logic [31:0] i_if_addr;
    logic        o_if_rsp_valid;
    logic        o_if_rsp_err;
    logic [31:0] o_if_rdata;

    logic        i_ls_req_valid;
    logic        o_ls_req_ready;
    logic [31:0] i_ls_addr;
    logic        i_ls_wen;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_wmask;
    logic        o_ls_rsp_valid;
    logic        o_ls_rsp_err;
    logic [31:0] o_ls_rdata;

    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_if_req_valid, i_if_addr,
        output o_if_req_ready, o_if_rsp_valid, o_if_rsp_err, o_if_rdata,
        input  i_ls_req_valid, i_ls_addr, i_ls_wen, i_ls_wdata, i_ls_wmask,
        output o_ls_req_ready, o_ls_rsp_valid, o_ls_rsp_err, o_ls_rdata,
        output o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
        input  i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata
    );

    modport master (
        output i_if_req_valid, i_if_addr,
        input  o_if_req_ready, o_if_rsp_valid, o_if_rsp_err, o_if_rdata,
        output i_ls_req_valid, i_ls_addr, i_ls_wen, i_ls_wdata, i_ls_wmask,
        input  o_ls_req_ready, o_ls_rsp_valid, o_ls_rsp_err, o_ls_rdata,
        input  o_mem_req_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
        output i_mem_req_ready, i_mem_rsp_valid, i_mem_rdata
    );
endinterface

// File: rtl/letc_core_mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store, one transaction in flight.
// Optional LETC_MEM_ARB_ROUND_ROBIN_EN: alternate the winner when both requesters are valid.
module letc_core_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMER_WIDTH    = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    letc_core_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
        TIMEOUT_EN ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_e                 state_q;
    logic                   grant_ls_q;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic                   mem_req_valid_q;
    logic [31:0]            addr_q;
    logic                   wen_q;
    logic [31:0]            wdata_q;
    logic [3:0]             wmask_q;

    logic pick_ls;
    logic accept;
    logic in_resp;
    logic rsp_hit;
    logic expire;
    logic rsp_fire;

`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
    logic last_ls_q;
    // On contention the requester that did not win last time goes first.
    assign pick_ls = bus.i_ls_req_valid & (~bus.i_if_req_valid | ~last_ls_q);
`else
    assign pick_ls = bus.i_ls_req_valid;
`endif

    assign accept   = (state_q == IDLE) & (bus.i_if_req_valid | bus.i_ls_req_valid);
    assign in_resp  = (state_q == RESP);
    assign rsp_hit  = in_resp & bus.i_mem_rsp_valid;
    // A real response in the expiry cycle takes precedence over the error.
    assign expire   = TIMEOUT_EN & in_resp & ~bus.i_mem_rsp_valid & (timer_q == TIMER_LAST);
    assign rsp_fire = rsp_hit | expire;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign bus.o_if_req_ready = i_rst_n & accept & ~pick_ls;
    assign bus.o_ls_req_ready = i_rst_n & accept &  pick_ls;

    assign bus.o_if_rsp_valid = rsp_fire & ~grant_ls_q;
    assign bus.o_if_rsp_err   = expire   & ~grant_ls_q;
    assign bus.o_if_rdata     = (rsp_hit & ~grant_ls_q) ? bus.i_mem_rdata : '0;
    assign bus.o_ls_rsp_valid = rsp_fire &  grant_ls_q;
    assign bus.o_ls_rsp_err   = expire   &  grant_ls_q;
    assign bus.o_ls_rdata     = (rsp_hit &  grant_ls_q) ? bus.i_mem_rdata : '0;

    assign bus.o_mem_req_valid = mem_req_valid_q;
    assign bus.o_mem_addr      = addr_q;
    assign bus.o_mem_wen       = wen_q;
    assign bus.o_mem_wdata     = wdata_q;
    assign bus.o_mem_wmask     = wmask_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= IDLE;
            grant_ls_q      <= 1'b0;
            timer_q         <= '0;
            mem_req_valid_q <= 1'b0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
            last_ls_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_ls_q      <= pick_ls;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= REQ;
`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
                        last_ls_q       <= pick_ls;
`endif
                        if (pick_ls) begin
                            addr_q  <= bus.i_ls_addr;
                            wen_q   <= bus.i_ls_wen;
                            wdata_q <= bus.i_ls_wdata;
                            wmask_q <= bus.i_ls_wmask;
                        end else begin
                            // Fetches are always plain word reads.
                            addr_q  <= bus.i_if_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= 4'h0;
                        end
                    end
                end
                REQ: begin
                    if (bus.i_mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        timer_q         <= '0;
                        state_q         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_fire) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TIMER_WIDTH'(1);
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_letc_core_mem_arbiter.sv
// Bench for letc_core_mem_arbiter: directed cycle table, hand sequences, randomized model comparison.
module tb_letc_core_mem_arbiter;
    localparam int TO = 4;

    typedef struct {
        string          name;
        logic [136:0]   stim;
        logic [139:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    letc_core_mem_arbiter_if bus ();

    letc_core_mem_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .TIMER_WIDTH   (3)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [136:0] st(bit ifv, logic [31:0] ifa, bit lsv, logic [31:0] lsa,
                                        bit w, logic [31:0] wd, logic [3:0] wm,
                                        bit mr, bit rv, logic [31:0] rd);
        return {ifv, ifa, lsv, lsa, w, wd, wm, mr, rv, rd};
    endfunction

    function automatic logic [139:0] ex(bit ifr, bit lsr, bit mv, logic [31:0] ma, bit mw,
                                        logic [31:0] md, logic [3:0] mm,
                                        bit ifv, bit ife, logic [31:0] ifd,
                                        bit lsv, bit lse, logic [31:0] lsd);
        return {ifr, lsr, mv, ma, mw, md, mm, ifv, ife, ifd, lsv, lse, lsd};
    endfunction

    function automatic logic [139:0] act();
        return {bus.o_if_req_ready, bus.o_ls_req_ready, bus.o_mem_req_valid, bus.o_mem_addr,
                bus.o_mem_wen, bus.o_mem_wdata, bus.o_mem_wmask,
                bus.o_if_rsp_valid, bus.o_if_rsp_err, bus.o_if_rdata,
                bus.o_ls_rsp_valid, bus.o_ls_rsp_err, bus.o_ls_rdata};
    endfunction

    task automatic drive(input logic [136:0] s);
        {bus.i_if_req_valid, bus.i_if_addr, bus.i_ls_req_valid, bus.i_ls_addr, bus.i_ls_wen,
         bus.i_ls_wdata, bus.i_ls_wmask, bus.i_mem_req_ready, bus.i_mem_rsp_valid,
         bus.i_mem_rdata} = s;
    endtask

    task automatic chk(input string name, input logic [139:0] e);
        logic [139:0] a;
        a = act();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, a, e);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare 1ns later.
    task automatic cyc(input vec_t v);
        @(negedge clk);
        drive(v.stim);
        #1;
        chk(v.name, v.exp);
    endtask

    function automatic vec_t mkv(string nm, logic [136:0] s, logic [139:0] e);
        vec_t v;
        v.name = nm;
        v.stim = s;
        v.exp  = e;
        return v;
    endfunction

    // Transaction-level reference: a busy flag, whether the request was handed off,
    // how long we have waited for data, and the captured request.
    bit          m_busy, m_sent, m_ls, m_last_ls;
    int          m_wait;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_wmask;

    task automatic model_reset();
        m_busy = 0; m_sent = 0; m_ls = 0; m_last_ls = 0; m_wait = 0;
        m_addr = 0; m_wdata = 0; m_wen = 0; m_wmask = 0;
    endtask

    function automatic bit model_winner_ls();
        if (bus.i_ls_req_valid && bus.i_if_req_valid) begin
`ifdef LETC_MEM_ARB_ROUND_ROBIN_EN
            return !m_last_ls;
`else
            return 1'b1;
`endif
        end
        return bus.i_ls_req_valid;
    endfunction

    function automatic logic [139:0] model_exp();
        bit any, wls, hit, to;
        any = !m_busy && (bus.i_if_req_valid || bus.i_ls_req_valid);
        wls = model_winner_ls();
        hit = m_busy && m_sent && bus.i_mem_rsp_valid;
        to  = m_busy && m_sent && !bus.i_mem_rsp_valid && (m_wait == TO - 1);
        return ex(any && !wls, any && wls, m_busy && !m_sent, m_addr, m_wen, m_wdata, m_wmask,
                  (hit || to) && !m_ls, to && !m_ls, (hit && !m_ls) ? bus.i_mem_rdata : 32'h0,
                  (hit || to) && m_ls, to && m_ls, (hit && m_ls) ? bus.i_mem_rdata : 32'h0);
    endfunction

    task automatic model_step();
        if (!m_busy) begin
            if (bus.i_if_req_valid || bus.i_ls_req_valid) begin
                m_ls = model_winner_ls();
                m_last_ls = m_ls;
                m_busy = 1; m_sent = 0;
                m_addr  = m_ls ? bus.i_ls_addr  : bus.i_if_addr;
                m_wen   = m_ls ? bus.i_ls_wen   : 1'b0;
                m_wdata = m_ls ? bus.i_ls_wdata : 32'h0;
                m_wmask = m_ls ? bus.i_ls_wmask : 4'h0;
            end
        end else if (!m_sent) begin
            if (bus.i_mem_req_ready) begin
                m_sent = 1; m_wait = 0;
            end
        end else if (bus.i_mem_rsp_valid || m_wait == TO - 1) begin
            m_busy = 0;
        end else begin
            m_wait++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        logic [136:0] idle_s;
        idle_s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held with every request input active: all outputs must read 0.
        rst_n = 1'b0;
        drive(st(1, 32'h1000, 1, 32'h2000, 1, 32'h5, 4'hF, 1, 1, 32'hFFFF_FFFF));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", '0);
        @(negedge clk);
        drive(idle_s);
        rst_n = 1'b1;

        tbl.push_back(mkv("if_acc",  st(1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0),
                          ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv("if_req",  st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                          ex(0, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv("if_rsp",  st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF),
                          ex(0, 0, 0, 32'h1000, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0)));
        tbl.push_back(mkv("both_acc", st(1, 32'h3000, 1, 32'h2004, 1, 32'h1234_5678, 4'b0011, 0, 0, 0),
                          ex(0, 1, 0, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv("ls_req",  st(1, 32'h3000, 1, 32'h2004, 1, 32'h1234_5678, 4'b0011, 1, 0, 0),
                          ex(0, 0, 1, 32'h2004, 1, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv("ls_rsp",  st(1, 32'h3000, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_5555),
                          ex(0, 0, 0, 32'h2004, 1, 32'h1234_5678, 4'b0011, 0, 0, 0, 1, 0, 32'hAAAA_5555)));
        tbl.push_back(mkv("if_acc2", st(1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0),
                          ex(1, 0, 0, 32'h2004, 1, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv("if_req2", st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                          ex(0, 0, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mkv("if_rsp2", st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D),
                          ex(0, 0, 0, 32'h3000, 0, 0, 0, 1, 0, 32'h0BAD_F00D, 0, 0, 0)));
        tbl.push_back(mkv("stray_rsp", st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF),
                          ex(0, 0, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        foreach (tbl[i]) cyc(tbl[i]);

        // Backpressure: five cycles of mem not ready, fields must not move.
        cyc(mkv("bp_acc", st(0, 0, 1, 32'h4008, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0),
                ex(0, 1, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < 5; i++)
            cyc(mkv("bp_hold", st(1, 32'h5000, 1, 32'h9999, 0, 0, 0, 0, 0, 0),
                    ex(0, 0, 1, 32'h4008, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 0, 0, 0)));
        cyc(mkv("bp_go", st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                ex(0, 0, 1, 32'h4008, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 0, 0, 0)));

        // Timeout: silence in RESP, error on the fourth RESP cycle, late response dropped.
        for (int i = 0; i < TO - 1; i++)
            cyc(mkv("to_wait", st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1111_1111),
                    ex(0, 0, 0, 32'h4008, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 0, 0, 0)));
        cyc(mkv("to_err", st(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1111_1111),
                ex(0, 0, 0, 32'h4008, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 1, 1, 0)));
        cyc(mkv("to_late", st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222),
                ex(0, 0, 0, 32'h4008, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 0, 0, 0)));

        // Response landing in the expiry cycle wins over the error.
        cyc(mkv("rx_acc", st(1, 32'h6000, 0, 0, 0, 0, 0, 0, 0, 0),
                ex(1, 0, 0, 32'h4008, 1, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 0, 0, 0)));
        cyc(mkv("rx_req", st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                ex(0, 0, 1, 32'h6000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < TO - 1; i++)
            cyc(mkv("rx_wait", idle_s, ex(0, 0, 0, 32'h6000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        cyc(mkv("rx_hit", st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3333_4444),
                ex(0, 0, 0, 32'h6000, 0, 0, 0, 1, 0, 32'h3333_4444, 0, 0, 0)));

        // Asynchronous reset while waiting for a response.
        cyc(mkv("mr_acc", st(1, 32'h7000, 0, 0, 0, 0, 0, 0, 0, 0),
                ex(1, 0, 0, 32'h6000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        cyc(mkv("mr_req", st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                ex(0, 0, 1, 32'h7000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        cyc(mkv("mr_pre", st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55),
                ex(0, 0, 0, 32'h7000, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0)));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_async", '0);
        @(posedge clk);
        @(negedge clk);
        drive(st(1, 32'h8000, 0, 0, 0, 0, 0, 0, 1, 32'h66));
        rst_n = 1'b1;
        #1;
        chk("mr_first", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(mkv("mr_req2", st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0),
                ex(0, 0, 1, 32'h8000, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        cyc(mkv("mr_rsp2", st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9),
                ex(0, 0, 0, 32'h8000, 0, 0, 0, 1, 0, 32'h9, 0, 0, 0)));

        // Randomized traffic against the reference model.
        @(negedge clk);
        drive(idle_s);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.i_if_req_valid  = ($urandom_range(0, 2) == 0);
            bus.i_if_addr       = $urandom;
            bus.i_ls_req_valid  = ($urandom_range(0, 2) == 0);
            bus.i_ls_addr       = $urandom;
            bus.i_ls_wen        = $urandom_range(0, 1);
            bus.i_ls_wdata      = $urandom;
            bus.i_ls_wmask      = 4'($urandom_range(0, 15));
            bus.i_mem_req_ready = ($urandom_range(0, 2) != 0);
            bus.i_mem_rsp_valid = ($urandom_range(0, 3) == 0);
            bus.i_mem_rdata     = $urandom;
            #1;
            chk("rand", model_exp());
            @(posedge clk);
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
